// File: rtl/led_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner driving one shared decoder, with blank guard and leading-zero suppression.
// All outputs registered; LOAD never stalls: the newest pending word commits at the frame boundary (or at once when idle) and ACK pulses.
module led_scan_ctrl #(
   parameter int DIVIDER   = 1000,
   parameter int BLANK_CYC = 100
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_en,
   input  logic        i_load,
   input  logic [15:0] i_data,
   input  logic        i_lzs,
   input  logic [3:0]  i_dp_mask,
   output logic        o_ack,
   output logic        o_dec_en,
   output logic [3:0]  o_dec_a,
   output logic [3:0]  o_dig,
   output logic        o_dp
);

   localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(DIVIDER - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BLANK,
      S_SHOW
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_idx;
   logic [15:0]   r_stage;
   logic [15:0]   r_shadow;
   logic          r_pend;
   logic          r_ack;
   logic          r_dec_en;
   logic [3:0]    r_dec_a;
   logic [3:0]    r_dig;
   logic          r_dp;

   logic [3:0]    w_supp;
   logic [3:0]    w_digit;
   logic [3:0]    w_lit_dig;
   logic          w_lit_dp;
   logic          w_idle;
   logic          w_boundary;

   // A digit is dark when it and every more-significant digit are zero; digit 0 always shows.
   assign w_supp[0] = 1'b0;
   assign w_supp[1] = i_lzs && (r_shadow[15:4]  == 12'd0);
   assign w_supp[2] = i_lzs && (r_shadow[15:8]  == 8'd0);
   assign w_supp[3] = i_lzs && (r_shadow[15:12] == 4'd0);

   assign w_digit    = r_shadow[{r_idx, 2'b00} +: 4];
   assign w_lit_dig  = w_supp[r_idx] ? 4'hF : ~(4'b0001 << r_idx);
   assign w_lit_dp   = w_supp[r_idx] | ~i_dp_mask[r_idx];
   assign w_idle     = (r_state == S_IDLE) || !i_en;
   assign w_boundary = (r_state == S_SHOW) && (r_idx == 2'd3) && (r_cnt == CNT_LAST);

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_idx    <= 2'd0;
         r_stage  <= 16'd0;
         r_shadow <= 16'd0;
         r_pend   <= 1'b0;
         r_ack    <= 1'b0;
         r_dec_en <= 1'b0;
         r_dec_a  <= 4'd0;
         r_dig    <= 4'hF;
         r_dp     <= 1'b1;
      end else begin
         r_ack <= 1'b0;
         if (i_load) begin
            r_stage <= i_data;
         end

         // Display word only changes while idle or between frames, so a frame never mixes words.
         if (w_idle) begin
            if (i_load) begin
               r_shadow <= i_data;
               r_ack    <= 1'b1;
            end else if (r_pend) begin
               r_shadow <= r_stage;
               r_ack    <= 1'b1;
            end
            r_pend <= 1'b0;
         end else if (w_boundary && (r_pend || i_load)) begin
            r_shadow <= i_load ? i_data : r_stage;
            r_pend   <= 1'b0;
            r_ack    <= 1'b1;
         end else if (i_load) begin
            r_pend <= 1'b1;
         end

         if (!i_en) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= 2'd0;
            r_dec_en <= 1'b0;
            r_dig    <= 4'hF;
            r_dp     <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state <= S_BLANK;
                  r_cnt   <= '0;
               end
               S_BLANK: begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == BLANK_LAST) begin
                     r_state  <= S_SHOW;
                     r_dec_en <= 1'b1;
                     r_dec_a  <= w_digit;
                     r_dig    <= w_lit_dig;
                     r_dp     <= w_lit_dp;
                  end
               end
               S_SHOW: begin
                  if (r_cnt == CNT_LAST) begin
                     r_state  <= S_BLANK;
                     r_cnt    <= '0;
                     r_idx    <= r_idx + 2'd1;
                     r_dec_en <= 1'b0;
                     r_dig    <= 4'hF;
                     r_dp     <= 1'b1;
                  end else begin
                     // DP mask and LZS are live inputs, so keep refreshing while lit.
                     r_cnt <= r_cnt + 1'b1;
                     r_dig <= w_lit_dig;
                     r_dp  <= w_lit_dp;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign o_ack    = r_ack;
   assign o_dec_en = r_dec_en;
   assign o_dec_a  = r_dec_a;
   assign o_dig    = r_dig;
   assign o_dp     = r_dp;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl with DIVIDER=8, BLANK_CYC=2; loads feed a queue of expected display words popped on ACK.
module tb_led_scan_ctrl;

   localparam int DIV = 8;
   localparam int BLK = 2;

   logic        clk = 1'b0;
   logic        rstn, en, load, lzs;
   logic [15:0] data;
   logic [3:0]  dp_mask;
   logic        ack, dec_en, dp;
   logic [3:0]  dec_a, dig;

   int          n_tests    = 0;
   int          n_fail     = 0;
   int          n_acks     = 0;
   int          n_exp_acks = 0;
   logic [15:0] exp_q[$];
   logic [15:0] cur_exp   = 16'd0;
   logic [3:0]  last_deca = 4'd0;

   always #5 clk = ~clk;

   led_scan_ctrl #(.DIVIDER(DIV), .BLANK_CYC(BLK)) dut (
      .i_clk     (clk),
      .i_rstn    (rstn),
      .i_en      (en),
      .i_load    (load),
      .i_data    (data),
      .i_lzs     (lzs),
      .i_dp_mask (dp_mask),
      .o_ack     (ack),
      .o_dec_en  (dec_en),
      .o_dec_a   (dec_a),
      .o_dig     (dig),
      .o_dp      (dp)
   );

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // A second LOAD before the first is acknowledged replaces it, unless the display is idle.
   task automatic push_exp(input logic [15:0] v, input bit idle);
      if (!idle && exp_q.size() != 0) begin
         exp_q[exp_q.size() - 1] = v;
      end else begin
         exp_q.push_back(v);
         n_exp_acks++;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (ack) begin
         n_acks++;
         n_tests++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL spurious_ack: observed ack=1 expected no pending word");
         end
         if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
      end
   endtask

   task automatic run_frame(input string name, input int la, input logic [15:0] da,
                            input int lb, input logic [15:0] db, input int stop);
      logic       exp_ack;
      logic       lit, supp, dp_e, ack_e;
      logic [1:0] k;
      logic [3:0] dig_e;
      int         off;
      exp_ack = (exp_q.size() != 0);
      for (int p = 0; p <= stop; p++) begin
         tick();
         k     = 2'(p / DIV);
         off   = p % DIV;
         lit   = (off >= BLK);
         supp  = lzs && (k != 2'd0) && ((cur_exp >> (4 * int'(k))) == 16'd0);
         dig_e = 4'hF;
         dp_e  = 1'b1;
         ack_e = (p == 0) ? exp_ack : 1'b0;
         if (lit) begin
            last_deca = cur_exp[{k, 2'b00} +: 4];
            if (!supp) begin
               dig_e = ~(4'b0001 << k);
               dp_e  = ~dp_mask[k];
            end
         end
         n_tests++;
         assert (dig === dig_e) else begin
            n_fail++; $error("FAIL %s p%0d dig: observed %h expected %h", name, p, dig, dig_e);
         end
         n_tests++;
         assert (dec_a === last_deca) else begin
            n_fail++; $error("FAIL %s p%0d dec_a: observed %h expected %h", name, p, dec_a, last_deca);
         end
         n_tests++;
         assert (dec_en === lit) else begin
            n_fail++; $error("FAIL %s p%0d dec_en: observed %b expected %b", name, p, dec_en, lit);
         end
         n_tests++;
         assert (dp === dp_e) else begin
            n_fail++; $error("FAIL %s p%0d dp: observed %b expected %b", name, p, dp, dp_e);
         end
         n_tests++;
         assert (ack === ack_e) else begin
            n_fail++; $error("FAIL %s p%0d ack: observed %b expected %b", name, p, ack, ack_e);
         end
         if (p == la) begin
            load = 1'b1; data = da; push_exp(da, 1'b0);
         end else if (p == lb) begin
            load = 1'b1; data = db; push_exp(db, 1'b0);
         end else begin
            load = 1'b0;
         end
      end
   endtask

   task automatic check_dark(input string name, input logic [3:0] exp_a);
      n_tests++;
      assert (dig === 4'hF) else begin
         n_fail++; $error("FAIL %s dig: observed %h expected f", name, dig);
      end
      n_tests++;
      assert (dec_en === 1'b0) else begin
         n_fail++; $error("FAIL %s dec_en: observed %b expected 0", name, dec_en);
      end
      n_tests++;
      assert (dp === 1'b1) else begin
         n_fail++; $error("FAIL %s dp: observed %b expected 1", name, dp);
      end
      n_tests++;
      assert (dec_a === exp_a) else begin
         n_fail++; $error("FAIL %s dec_a: observed %h expected %h", name, dec_a, exp_a);
      end
      n_tests++;
      assert (ack === 1'b0) else begin
         n_fail++; $error("FAIL %s ack: observed %b expected 0", name, ack);
      end
   endtask

   initial begin
      rstn = 1'b0; en = 1'b0; load = 1'b0; data = 16'd0; lzs = 1'b0; dp_mask = 4'd0;
      repeat (3) tick();
      check_dark("reset", 4'd0);
      rstn = 1'b1;
      tick();
      check_dark("idle", 4'd0);

      // Idle load commits immediately.
      load = 1'b1; data = 16'h4321; push_exp(16'h4321, 1'b1);
      tick();
      n_tests++;
      assert (ack === 1'b1) else begin
         n_fail++; $error("FAIL idle_ack_4321: observed %b expected 1", ack);
      end
      load = 1'b0;
      tick();
      check_dark("idle_after_ack", 4'd0);

      en = 1'b1;
      run_frame("startup",    -1, 16'h0,     -1, 16'h0,     31);
      run_frame("load9876",   12, 16'h9876,  -1, 16'h0,     31);
      run_frame("dbl_load",    3, 16'h1111,  20, 16'h2222,  31);
      lzs = 1'b1;
      run_frame("show2222",   31, 16'h0050,  -1, 16'h0,     31);
      dp_mask = 4'b1000;
      run_frame("lzs0050",    31, 16'h0000,  -1, 16'h0,     31);
      run_frame("lzs0000",    -1, 16'h0,     -1, 16'h0,     31);
      dp_mask = 4'b0001;
      run_frame("lzs0000_dp", 31, 16'h0705,  -1, 16'h0,     31);
      run_frame("en_off",     -1, 16'h0,     -1, 16'h0,     20);

      en = 1'b0;
      tick();
      check_dark("en_low", last_deca);
      tick();
      check_dark("en_low_hold", last_deca);
      en = 1'b1;
      run_frame("reenable",   -1, 16'h0,     -1, 16'h0,     31);
      run_frame("rst_pend",    5, 16'h5555,  -1, 16'h0,     10);

      // Reset discards the pending word without acknowledging it.
      rstn = 1'b0; en = 1'b0;
      n_exp_acks -= exp_q.size();
      exp_q.delete();
      cur_exp   = 16'd0;
      last_deca = 4'd0;
      tick();
      check_dark("rst_mid", 4'd0);
      tick();
      check_dark("rst_hold", 4'd0);
      rstn = 1'b1; en = 1'b1;
      run_frame("after_rst",  -1, 16'h0,     -1, 16'h0,     31);

      en = 1'b0;
      tick();
      load = 1'b1; data = 16'hABCD; push_exp(16'hABCD, 1'b1);
      tick();
      n_tests++;
      assert (ack === 1'b1) else begin
         n_fail++; $error("FAIL idle_ack_abcd: observed %b expected 1", ack);
      end
      load = 1'b0; lzs = 1'b0; dp_mask = 4'b0000; en = 1'b1;
      run_frame("showABCD",   -1, 16'h0,     -1, 16'h0,     31);

      n_tests++;
      assert (n_acks === n_exp_acks) else begin
         n_fail++; $error("FAIL ack_total: observed %0d expected %0d", n_acks, n_exp_acks);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
